// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: requester, transmitter and status signals around the TX arbiter
interface udp_tx_arbiter_if;
    logic        req0;
    logic        req1;
    logic [11:0] len0;
    logic [11:0] len1;
    logic [3:0]  rd_da0;
    logic [3:0]  rd_da1;
    logic        grant0;
    logic        grant1;
    logic        rd_en0;
    logic        rd_en1;
    logic        done0;
    logic        done1;
    logic        tx_go;
    logic [11:0] data_len;
    logic        fifo_rq;
    logic [3:0]  fifo_da;
    logic        mii_tx_en;
    logic        busy;
    logic        err_timeout;

    modport master (
        input  req0, req1, len0, len1, rd_da0, rd_da1, fifo_rq, mii_tx_en,
        output grant0, grant1, rd_en0, rd_en1, done0, done1, tx_go, data_len,
               fifo_da, busy, err_timeout
    );

    modport slave (
        output req0, req1, len0, len1, rd_da0, rd_da1, fifo_rq, mii_tx_en,
        input  grant0, grant1, rd_en0, rd_en1, done0, done1, tx_go, data_len,
               fifo_da, busy, err_timeout
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: two-source round-robin scheduler for the ip_protocol transmitter,
// with start timeout and inter-frame gap enforcement.
module udp_tx_arbiter #(
    parameter int IFG_CYCLES    = 24,
    parameter int START_TIMEOUT = 64
) (
    input  logic               mii_tx_clk,
    input  logic               rst_n,
    udp_tx_arbiter_if.master   bus
);
    typedef enum logic [2:0] {IDLE, GO, WAIT_START, SEND, GAP} state_t;

    localparam logic [15:0] TO_LAST  = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    state_t      state;
    logic        last_grant;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        elig0;
    logic        elig1;
    logic        pick1;
    logic        in_send;

    assign elig0   = bus.req0 && (bus.len0 != 12'd0);
    assign elig1   = bus.req1 && (bus.len1 != 12'd0);
    // on contention source 1 wins only if source 0 was served last
    assign pick1   = elig1 && (!elig0 || !last_grant);
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign in_send = (state == SEND);

    assign bus.rd_en0  = in_send && bus.fifo_rq && bus.grant0;
    assign bus.rd_en1  = in_send && bus.fifo_rq && bus.grant1;
    assign bus.fifo_da = !in_send   ? 4'h0 :
                         bus.grant0 ? bus.rd_da0 :
                         bus.grant1 ? bus.rd_da1 : 4'h0;

    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            cnt             <= 16'd0;
            bus.grant0      <= 1'b0;
            bus.grant1      <= 1'b0;
            bus.done0       <= 1'b0;
            bus.done1       <= 1'b0;
            bus.tx_go       <= 1'b0;
            bus.data_len    <= 12'd0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.tx_go       <= 1'b0;
            bus.done0       <= 1'b0;
            bus.done1       <= 1'b0;
            bus.err_timeout <= 1'b0;
            case (state)
                IDLE: if (elig0 || elig1) begin
                    bus.grant0   <= !pick1;
                    bus.grant1   <= pick1;
                    bus.data_len <= pick1 ? bus.len1 : bus.len0;
                    last_grant   <= pick1;
                    bus.tx_go    <= 1'b1;
                    bus.busy     <= 1'b1;
                    state        <= GO;
                end
                GO: begin
                    cnt   <= 16'd0;
                    state <= WAIT_START;
                end
                WAIT_START: if (bus.mii_tx_en) begin
                    state <= SEND;
                end else if (cnt >= TO_LAST) begin
                    bus.err_timeout <= 1'b1;
                    bus.done0       <= bus.grant0;
                    bus.done1       <= bus.grant1;
                    bus.grant0      <= 1'b0;
                    bus.grant1      <= 1'b0;
                    cnt             <= 16'd0;
                    state           <= GAP;
                end else begin
                    cnt <= cnt_inc;
                end
                SEND: if (!bus.mii_tx_en) begin
                    bus.done0  <= bus.grant0;
                    bus.done1  <= bus.grant1;
                    bus.grant0 <= 1'b0;
                    bus.grant1 <= 1'b0;
                    cnt        <= 16'd0;
                    state      <= GAP;
                end
                GAP: if (cnt >= IFG_LAST) begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end else begin
                    cnt <= cnt_inc;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed checks of grant order, timing, nibble routing, timeout and reset.
module tb_udp_tx_arbiter;
    localparam int IFG = 24;
    localparam int TO  = 64;

    logic mii_tx_clk = 1'b0;
    logic rst_n      = 1'b0;
    int   cyc        = 0;
    int   n_run      = 0;
    int   n_fail     = 0;

    udp_tx_arbiter_if bus();

    udp_tx_arbiter #(.IFG_CYCLES(IFG), .START_TIMEOUT(TO)) dut (
        .mii_tx_clk (mii_tx_clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #20 mii_tx_clk = ~mii_tx_clk;
    always @(posedge mii_tx_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mii_tx_clk);
        #1;
    endtask

    task automatic wait_go(output int at);
        bit seen;
        seen = 0;
        at   = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (bus.tx_go) begin
                seen = 1;
                at   = cyc;
            end
        end
        if (!seen) chk("go_seen", 0, 1);
    endtask

    task automatic frame(input logic g1, input int prev_fall, output int fall);
        int g;
        logic [3:0] exp_da;
        exp_da = g1 ? 4'hA : 4'h5;
        wait_go(g);
        chk("grant1", bus.grant1, g1);
        chk("grant0", bus.grant0, !g1);
        if (prev_fall >= 0) chk("ifg", g - prev_fall, IFG + 2);
        tick();
        bus.fifo_rq = 1'b1;
        #1;
        chk("ws_rd_en", {bus.rd_en1, bus.rd_en0}, 2'b00);
        chk("ws_fifo_da", bus.fifo_da, 4'h0);
        bus.fifo_rq = 1'b0;
        repeat (4) tick();
        bus.mii_tx_en = 1'b1;
        repeat (2) tick();
        bus.fifo_rq = 1'b1;
        #1;
        chk("fifo_da", bus.fifo_da, exp_da);
        chk("rd_en", {bus.rd_en1, bus.rd_en0}, g1 ? 2'b10 : 2'b01);
        bus.fifo_rq = 1'b0;
        #1;
        chk("rd_en_off", {bus.rd_en1, bus.rd_en0}, 2'b00);
        repeat (8) tick();
        bus.mii_tx_en = 1'b0;
        fall = cyc;
        tick();
        chk("done", {bus.done1, bus.done0}, g1 ? 2'b10 : 2'b01);
        chk("grant_clr", {bus.grant1, bus.grant0}, 2'b00);
    endtask

    initial begin
        int g, e, b, fall, n_go, n_to, n_busy, n_g1;
        bus.req0 = 0; bus.req1 = 0; bus.len0 = 0; bus.len1 = 0;
        bus.rd_da0 = 4'h5; bus.rd_da1 = 4'hA;
        bus.fifo_rq = 0; bus.mii_tx_en = 0;

        // reset state
        repeat (2) tick();
        chk("rst_grant", {bus.grant1, bus.grant0}, 2'b00);
        chk("rst_tx_go", bus.tx_go, 0);
        chk("rst_data_len", bus.data_len, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", {bus.done1, bus.done0, bus.err_timeout}, 3'b000);
        rst_n = 1'b1;
        tick();

        // single frame from source 0
        bus.req0 = 1; bus.len0 = 12'd29;
        tick();
        chk("f0_tx_go", bus.tx_go, 1);
        chk("f0_grant0", bus.grant0, 1);
        chk("f0_data_len", bus.data_len, 29);
        chk("f0_busy", bus.busy, 1);
        n_go = 0; n_to = 0;
        repeat (5) begin
            tick();
            n_go += int'(bus.tx_go);
        end
        bus.mii_tx_en = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 10) begin bus.len0 = 12'd7; bus.req0 = 0; end
            n_go += int'(bus.tx_go);
            n_to += int'(bus.err_timeout);
        end
        chk("f0_one_go", n_go, 0);
        chk("f0_no_to", n_to, 0);
        chk("f0_len_hold", bus.data_len, 29);
        bus.mii_tx_en = 0;
        tick();
        chk("f0_done0", bus.done0, 1);
        chk("f0_grant_clr", bus.grant0, 0);
        tick();
        chk("f0_done_pulse", bus.done0, 0);

        // round robin with both sources requesting
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.req0 = 1; bus.req1 = 1; bus.len0 = 12'd10; bus.len1 = 12'd20;
        fall = -1;
        for (int i = 0; i < 4; i++) frame(logic'(i % 2), fall, fall);
        bus.req1 = 0;

        // start timeout on source 0
        wait_go(g);
        chk("to_grant0", bus.grant0, 1);
        chk("to_len", bus.data_len, 10);
        e = -1;
        for (int i = 0; i < 300 && e < 0; i++) begin
            tick();
            if (bus.err_timeout) e = cyc;
        end
        chk("to_lat", e - g, TO + 1);
        chk("to_done0", bus.done0, 1);
        chk("to_grant_clr", bus.grant0, 0);
        chk("to_busy", bus.busy, 1);
        bus.req0 = 0;
        b = -1;
        for (int i = 0; i < 300 && b < 0; i++) begin
            tick();
            if (!bus.busy) b = cyc;
        end
        chk("to_gap", b - e, IFG);

        // zero-length request is never served
        bus.req1 = 1; bus.len1 = 0;
        n_go = 0; n_busy = 0; n_g1 = 0;
        repeat (60) begin
            tick();
            n_go += int'(bus.tx_go);
            n_busy += int'(bus.busy);
            n_g1 += int'(bus.grant1 | bus.done1);
        end
        chk("z_tx_go", n_go, 0);
        chk("z_busy", n_busy, 0);
        chk("z_grant1", n_g1, 0);
        bus.req1 = 0;

        // asynchronous reset in the middle of a frame
        bus.req0 = 1; bus.len0 = 12'd50;
        wait_go(g);
        repeat (2) tick();
        bus.mii_tx_en = 1;
        repeat (3) tick();
        bus.fifo_rq = 1;
        #1;
        chk("ms_rd_en0", bus.rd_en0, 1);
        rst_n = 0;
        #1;
        chk("ms_grant", {bus.grant1, bus.grant0}, 2'b00);
        chk("ms_busy", bus.busy, 0);
        chk("ms_data_len", bus.data_len, 0);
        chk("ms_rd_en", {bus.rd_en1, bus.rd_en0}, 2'b00);
        chk("ms_fifo_da", bus.fifo_da, 4'h0);
        tick();
        rst_n = 1; bus.mii_tx_en = 0; bus.fifo_rq = 0;
        wait_go(g);
        chk("ms_regrant0", bus.grant0, 1);
        chk("ms_relen", bus.data_len, 50);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
